// File: rtl/uart_receiver.sv
// Purpose: 8N1 UART receiver with 2-flop input synchronizer, mid-bit sampling and framing-error detection.
// Latency: VALID/FERR pulse CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 3 cycles after the UART_RX falling edge.
// Backpressure: none; DATA holds the last good byte and the consumer must take it before the next VALID.
module uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       UART_RX,
    output logic [7:0] DATA,
    output logic       VALID,
    output logic       FERR,
    output logic       BUSY
);

    // Counter terminal values: one full bit period, and half a bit (floor) to land in the start-bit centre.
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  idx, idx_nxt;
    logic [7:0]  shift, shift_nxt;
    logic [7:0]  data_nxt;
    logic        valid_nxt;
    logic        ferr_nxt;
    logic        rx_meta;
    logic        rx_s;

    // Two-flop synchronizer; resets to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= UART_RX;
            rx_s    <= rx_meta;
        end
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
            cnt   <= 16'd0;
            idx   <= 3'd0;
            shift <= 8'h00;
            DATA  <= 8'h00;
            VALID <= 1'b0;
            FERR  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            shift <= shift_nxt;
            DATA  <= data_nxt;
            VALID <= valid_nxt;
            FERR  <= ferr_nxt;
        end
    end

    // Next-state and datapath decisions; pulses default low so each lasts a single cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shift_nxt = shift;
        data_nxt  = DATA;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_nxt = ST_START;
                    cnt_nxt   = 16'd0;
                end
            end
            ST_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt = 16'd0;
                    if (!rx_s) begin
                        state_nxt = ST_DATA;
                        idx_nxt   = 3'd0;
                    end else begin
                        // Line went back high before mid-start: treat as a glitch.
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt == BIT_LAST) begin
                    shift_nxt[idx] = rx_s;
                    cnt_nxt        = 16'd0;
                    idx_nxt        = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_nxt = ST_STOP;
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            ST_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt = 16'd0;
                    if (rx_s) begin
                        data_nxt  = shift;
                        valid_nxt = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            ST_WAIT_HIGH: begin
                // Hold off until the line returns high so a break is not re-read as start bits.
                if (rx_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = 16'd0;
                idx_nxt   = 3'd0;
            end
        endcase
    end

    assign BUSY = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

    localparam int CPB = 16;
    localparam int LAT = (CPB / 2) + 9 * CPB;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       UART_RX = 1'b1;
    logic [7:0] DATA;
    logic       VALID;
    logic       FERR;
    logic       BUSY;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .UART_RX (UART_RX),
        .DATA    (DATA),
        .VALID   (VALID),
        .FERR    (FERR),
        .BUSY    (BUSY)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        bit         is_ferr;
        logic [7:0] data;
        int         t_fall;
        bit         chk_lat;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT emits a VALID or FERR pulse.
    bit prev_v = 1'b0;
    bit prev_f = 1'b0;
    always @(negedge CLK) begin
        exp_t e;
        int   d;
        if (VALID === 1'b1 || FERR === 1'b1) begin
            check("pulse_exclusive", {31'd0, VALID & FERR}, 32'd0);
            check("pulse_width", {30'd0, prev_v & VALID, prev_f & FERR}, 32'd0);
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pulse: VALID=%b FERR=%b DATA=0x%h, required no pulse", VALID, FERR, DATA);
            end else begin
                e = q.pop_front();
                check("pulse_kind_ferr", {31'd0, FERR}, {31'd0, e.is_ferr});
                check("data", {24'd0, DATA}, {24'd0, e.data});
                if (!e.is_ferr) check("busy_after_valid", {31'd0, BUSY}, 32'd0);
                if (e.chk_lat) begin
                    d = cyc - e.t_fall;
                    vectors++;
                    if (d < LAT + 3 || d > LAT + 5) begin
                        miscompares++;
                        $display("FAIL latency: got %0d cycles, required %0d..%0d", d, LAT + 3, LAT + 5);
                    end
                end
            end
        end
        prev_v = (VALID === 1'b1);
        prev_f = (FERR === 1'b1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Drives one 8N1 frame; optionally registers the expected pulse when the start edge goes out.
    task automatic send_frame(input logic [7:0] b, input int period, input bit stop_v,
                              input bit push, input bit e_ferr, input logic [7:0] e_data,
                              input bit chk_lat);
        logic [9:0] bits;
        bits = {stop_v, b, 1'b0};
        for (int j = 0; j < 10; j++) begin
            @(negedge CLK);
            UART_RX = bits[j];
            if (j == 0 && push) q.push_back(exp_t'{e_ferr, e_data, cyc, chk_lat});
            repeat (period - 1) @(negedge CLK);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge CLK);
            n++;
        end
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL %s: %0d expected pulses not seen, required 0 outstanding", tag, q.size());
            q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  {24'd0, DATA}, 32'd0);
        check({tag, "_valid"}, {31'd0, VALID}, 32'd0);
        check({tag, "_ferr"},  {31'd0, FERR}, 32'd0);
        check({tag, "_busy"},  {31'd0, BUSY}, 32'd0);
    endtask

    initial begin
        logic [7:0] b81;
        b81 = 8'h81;

        // Reset state
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RST_N = 1'b1;
        idle(5);

        // Single good frame
        send_frame(8'hA5, CPB, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1);
        drain("frame_a5");
        idle(10);

        // Back-to-back frames, no idle gap
        send_frame(8'h00, CPB, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        send_frame(8'hFF, CPB, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1);
        send_frame(8'h3C, CPB, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1);
        drain("back_to_back");
        idle(10);

        // 5-cycle low glitch on idle line
        @(negedge CLK);
        UART_RX = 1'b0;
        repeat (4) @(negedge CLK);
        check("glitch_busy_high", {31'd0, BUSY}, 32'd1);
        @(negedge CLK);
        UART_RX = 1'b1;
        repeat (12) @(negedge CLK);
        check("glitch_busy_low", {31'd0, BUSY}, 32'd0);
        check("glitch_data_held", {24'd0, DATA}, 32'h3C);
        idle(20);

        // Framing error, line held low, then a good frame
        send_frame(8'h55, CPB, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1);
        repeat (40) @(negedge CLK);
        check("break_busy_high", {31'd0, BUSY}, 32'd1);
        UART_RX = 1'b1;
        idle(CPB);
        send_frame(8'h12, CPB, 1'b1, 1'b1, 1'b0, 8'h12, 1'b1);
        drain("ferr_then_12");
        idle(10);

        // Reset during data bit 4 of 0x81
        @(negedge CLK);
        UART_RX = 1'b0;
        repeat (CPB - 1) @(negedge CLK);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            UART_RX = b81[k];
            repeat ((k == 4) ? 7 : CPB - 1) @(negedge CLK);
        end
        check("midframe_busy", {31'd0, BUSY}, 32'd1);
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        UART_RX = 1'b1;
        repeat (3) @(negedge CLK);
        check_reset_outputs("held_reset");
        RST_N = 1'b1;
        idle(20);
        send_frame(8'h7E, CPB, 1'b1, 1'b1, 1'b0, 8'h7E, 1'b1);
        drain("after_reset_7e");
        idle(20);

        // Baud tolerance: 15 and 17 cycles per bit
        send_frame(8'hC3, 15, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b0);
        drain("baud_15");
        idle(20);
        send_frame(8'hC3, 17, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b0);
        drain("baud_17");
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
